// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
// Controller states, Booth pair decode and operand extension.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'b00,
    BOOTH_ADD = 2'b01,
    BOOTH_SUB = 2'b10
  } booth_op_t;

  // {Q0,q_m1}: 01 adds M, 10 subtracts M, 00/11 leave A alone.
  function automatic booth_op_t booth_dec(
    input logic q0,
    input logic qm1
  );
    booth_op_t op;
    op = BOOTH_NOP;
    unique case (1'b1)
      (q0 & ~qm1): op = BOOTH_SUB;
      (~q0 & qm1): op = BOOTH_ADD;
      default:     op = BOOTH_NOP;
    endcase
    return op;
  endfunction

  // Fill bit for widening an operand: its sign when signed, else zero.
  function automatic logic ext_bit(
    input logic msb,
    input logic sgn
  );
    return msb & sgn;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/sub/nop on A, then an
// arithmetic right shift of {A,Q,q_m1} by one bit.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH+1:0] a,
  input  logic [WIDTH+1:0] m,
  input  logic [WIDTH:0]   q,
  input  logic             q_m1,
  output logic [WIDTH+1:0] a_nx,
  output logic [WIDTH:0]   q_nx,
  output logic             q_m1_nx
);

  booth_op_t        op;
  logic [WIDTH+1:0] sum;

  // Partial-product update chosen by the current Booth pair.
  always_comb begin
    op  = booth_dec(q[0], q_m1);
    sum = a;
    unique case (op)
      BOOTH_ADD: sum = a + m;
      BOOTH_SUB: sum = a + ~m + (WIDTH+2)'(1);
      default:   sum = a;
    endcase
  end

  assign a_nx    = {sum[WIDTH+1], sum[WIDTH+1:1]};
  assign q_nx    = {sum[0], q[WIDTH:1]};
  assign q_m1_nx = q[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned,
// valid/ready on both sides, one job in flight, sync flush.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 2);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH+1:0] a;
  logic [WIDTH+1:0] m;
  logic [WIDTH:0]   q;
  logic             q_m1;
  logic [CNT_W-1:0] count;
  logic             last;

  logic [WIDTH+1:0] a_nx;
  logic [WIDTH:0]   q_nx;
  logic             q_m1_nx;

  logic             m_fill;
  logic             q_fill;

  assign last   = (count == CNT_W'(1));
  assign m_fill = ext_bit(multiplicand[WIDTH-1], is_signed);
  assign q_fill = ext_bit(multiplier[WIDTH-1], is_signed);

  booth_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .a       (a),
    .m       (m),
    .q       (q),
    .q_m1    (q_m1),
    .a_nx    (a_nx),
    .q_nx    (q_nx),
    .q_m1_nx (q_m1_nx)
  );

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and handshake outputs; flush overrides everything.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = CALC;
      end
      CALC: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // Datapath: load widened operands, iterate, capture the product.
  // Operands are widened at accept, so the mode needs no register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a       <= '0;
      m       <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      count   <= '0;
      product <= '0;
    end else if (flush) begin
      a       <= '0;
      m       <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      count   <= '0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a     <= '0;
            m     <= {{2{m_fill}}, multiplicand};
            q     <= {q_fill, multiplier};
            q_m1  <= 1'b0;
            count <= CNT_W'(WIDTH + 1);
          end
        end
        CALC: begin
          a     <= a_nx;
          q     <= q_nx;
          q_m1  <= q_m1_nx;
          count <= count - CNT_W'(1);
          if (last) product <= {a_nx[WIDTH-2:0], q_nx};
        end
        default: begin
        end
      endcase
    end
  end

endmodule
